car_park_occupancy: RTL

- Downstream consumer of the car park entry/exit FSM: takes its `entered` / `exited` indications and maintains the live vehicle count.
- Provides a saturating occupancy counter, full/empty/near-full flags, a status state machine, and sticky overflow/underflow error capture.
- Outputs feed the display/gate-control logic.

---
 rtl/car_park_occupancy_if.sv | 65 ++++++
 rtl/car_park_occupancy.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/car_park_occupancy_if.sv
`default_nettype none
// ============================================================================
// Module   : car_park_occupancy_if
// Brief    : Event inputs and occupancy/status outputs of the car park counter.
//            BCD digit signals exist only when OCCUPANCY_BCD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface car_park_occupancy_if #(
    parameter int CAPACITY = 15
);
    localparam int COUNT_W = $clog2(CAPACITY + 1);

    logic               entered;
    logic               exited;
    logic               clear_err;
    logic [COUNT_W-1:0] count;
    logic               empty;
    logic               full;
    logic               near_full;
    logic [1:0]         status;
    logic               err_ovf;
    logic               err_unf;
`ifdef OCCUPANCY_BCD_EN
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_ones;
`endif

    // Upstream FSM / test driver side
    modport master (
        output entered,
        output exited,
        output clear_err,
`ifdef OCCUPANCY_BCD_EN
        input  bcd_tens,
        input  bcd_ones,
`endif
        input  count,
        input  empty,
        input  full,
        input  near_full,
        input  status,
        input  err_ovf,
        input  err_unf
    );

    // Occupancy counter side
    modport slave (
        input  entered,
        input  exited,
        input  clear_err,
`ifdef OCCUPANCY_BCD_EN
        output bcd_tens,
        output bcd_ones,
`endif
        output count,
        output empty,
        output full,
        output near_full,
        output status,
        output err_ovf,
        output err_unf
    );
endinterface

`default_nettype wire

// File: rtl/car_park_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : car_park_occupancy
// Brief    : Saturating car park occupancy counter with status FSM and sticky
//            over/underflow capture. Optional macro OCCUPANCY_BCD_EN adds
//            registered decimal digits of the count.
// Revision : 1.0 - initial release
// ============================================================================
module car_park_occupancy #(
    parameter int CAPACITY  = 15,
    parameter int NEAR_FULL = 12
) (
    input  wire logic           clk,
    input  wire logic           reset,
    car_park_occupancy_if.slave bus
);
    localparam int COUNT_W = $clog2(CAPACITY + 1);

    localparam logic [COUNT_W-1:0] c_CAPACITY  = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0] c_NEAR_FULL = COUNT_W'(NEAR_FULL);
    localparam logic [COUNT_W-1:0] c_ZERO      = '0;
    localparam logic [COUNT_W-1:0] c_ONE       = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_OPEN  = 2'b01,
        ST_FULL  = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    generate
        if (CAPACITY < 1 || CAPACITY > 255) begin : g_bad_capacity
            $error("car_park_occupancy: CAPACITY must be in 1..255");
        end
        if (NEAR_FULL > CAPACITY) begin : g_bad_near_full
            $error("car_park_occupancy: NEAR_FULL must not exceed CAPACITY");
        end
    endgenerate

    logic               r_entered_q;
    logic               r_exited_q;
    logic [COUNT_W-1:0] r_count;
    state_t             r_state;
    logic               r_err_ovf;
    logic               r_err_unf;

    logic               w_ent_ev;
    logic               w_ext_ev;
    logic               w_ovf;
    logic               w_unf;
    logic               w_clr;
    logic [COUNT_W-1:0] w_count_next;

    assign w_ent_ev = bus.entered & ~r_entered_q;
    assign w_ext_ev = bus.exited  & ~r_exited_q;

    // Simultaneous entry and exit cancel out and can never be a violation
    assign w_ovf = w_ent_ev & ~w_ext_ev & (r_count == c_CAPACITY);
    assign w_unf = w_ext_ev & ~w_ent_ev & (r_count == c_ZERO);
    assign w_clr = bus.clear_err & (r_state == ST_ERROR);

    always_comb begin
        w_count_next = r_count;
        if (w_ent_ev && !w_ext_ev && (r_count != c_CAPACITY)) begin
            w_count_next = r_count + c_ONE;
        end else if (w_ext_ev && !w_ent_ev && (r_count != c_ZERO)) begin
            w_count_next = r_count - c_ONE;
        end
    end

    function automatic state_t f_decode(input logic [COUNT_W-1:0] cnt);
        if (cnt == c_ZERO) begin
            return ST_EMPTY;
        end else if (cnt == c_CAPACITY) begin
            return ST_FULL;
        end
        return ST_OPEN;
    endfunction

    // History registers reset high so a level already present at release is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entered_q <= 1'b1;
            r_exited_q  <= 1'b1;
            r_count     <= c_ZERO;
            r_state     <= ST_EMPTY;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
        end else begin
            r_entered_q <= bus.entered;
            r_exited_q  <= bus.exited;
            r_count     <= w_count_next;
            r_err_ovf   <= w_ovf | (r_err_ovf & ~w_clr);
            r_err_unf   <= w_unf | (r_err_unf & ~w_clr);
            if (w_ovf || w_unf) begin
                r_state <= ST_ERROR;
            end else if ((r_state == ST_ERROR) && !bus.clear_err) begin
                r_state <= ST_ERROR;
            end else begin
                r_state <= f_decode(w_count_next);
            end
        end
    end

    assign bus.count     = r_count;
    assign bus.empty     = (r_count == c_ZERO);
    assign bus.full      = (r_count == c_CAPACITY);
    assign bus.near_full = (r_count >= c_NEAR_FULL);
    assign bus.status    = r_state;
    assign bus.err_ovf   = r_err_ovf;
    assign bus.err_unf   = r_err_unf;

`ifdef OCCUPANCY_BCD_EN
    generate
        if (CAPACITY > 99) begin : g_bad_bcd_capacity
            $error("car_park_occupancy: OCCUPANCY_BCD_EN needs CAPACITY <= 99");
        end
    endgenerate

    logic [7:0] w_count_ext;
    logic [3:0] r_bcd_tens;
    logic [3:0] r_bcd_ones;

    assign w_count_ext = 8'(r_count);

    // Digits follow the registered count, so they trail it by one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd_tens <= 4'd0;
            r_bcd_ones <= 4'd0;
        end else begin
            r_bcd_tens <= 4'(w_count_ext / 8'd10);
            r_bcd_ones <= 4'(w_count_ext % 8'd10);
        end
    end

    assign bus.bcd_tens = r_bcd_tens;
    assign bus.bcd_ones = r_bcd_ones;
`endif

endmodule

`default_nettype wire
